bram_uart_streamer: RTL and testbench

//  Parametrised inferred-BRAM byte streamer feeding a start/busy UART transmitter.

---
 rtl/bram_uart_streamer.sv | 159 +++++++++++++++
 tb/tb_bram_uart_streamer.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_uart_streamer.sv
// bram_uart_streamer: streams a BRAM address window into a start/busy UART tx.
// Macro STREAMER_CHECKSUM_EN appends a mod-2**DATA_W checksum word to each pass.
// Ports: clk, rst (sync, active-high); start/stop/loop_en pass control;
//  first_addr/last_addr window; w_en/w_addr/w_data memory write port;
//  tx_busy in, tx_start/tx_data out (handshake); active/cur_addr/done status.
module bram_uart_streamer #(
  parameter int    DATA_W    = 8,
  parameter int    ADDR_W    = 8,
  parameter string INIT_FILE = "mem_init.txt"
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  input  logic              w_en,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [DATA_W-1:0] tx_data,
  output logic              active,
  output logic [ADDR_W-1:0] cur_addr,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_SEND,
    S_WAIT,
    S_NEXT,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_n;
  logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] r_rdata;
  logic [DATA_W-1:0] r_tx_data;
  logic [ADDR_W-1:0] r_cur_addr;
  logic [ADDR_W-1:0] r_first;
  logic [ADDR_W-1:0] r_last;
  logic              r_tx_start;
  logic              w_last;
  logic              w_pass_end;

  // Read-first: the read samples the array before this edge's write lands.
  always_ff @(posedge clk) begin
    if (w_en) r_mem[w_addr] <= w_data;
    r_rdata <= r_mem[r_cur_addr];
  end

  assign w_last = (r_cur_addr == r_last);

`ifdef STREAMER_CHECKSUM_EN
  logic [DATA_W-1:0] r_csum;
  logic              r_csum_phase;
  // With a checksum the pass ends after the checksum word, not after last_addr.
  assign w_pass_end = r_csum_phase;
`else
  assign w_pass_end = w_last;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_state_n = S_FETCH;
      S_FETCH: w_state_n = S_LOAD;
      S_LOAD:  w_state_n = S_SEND;
      S_SEND:  if (r_tx_start && tx_busy) w_state_n = S_WAIT;
      S_WAIT:  if (!tx_busy) w_state_n = S_NEXT;
      S_NEXT: begin
        if (stop)
          w_state_n = S_DONE;
        else if (w_pass_end)
          w_state_n = loop_en ? S_FETCH : S_DONE;
`ifdef STREAMER_CHECKSUM_EN
        else if (w_last)
          w_state_n = S_SEND;
`endif
        else
          w_state_n = S_FETCH;
      end
      S_DONE:  w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cur_addr   <= '0;
      r_first      <= '0;
      r_last       <= '0;
      r_tx_data    <= '0;
      r_tx_start   <= 1'b0;
`ifdef STREAMER_CHECKSUM_EN
      r_csum       <= '0;
      r_csum_phase <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_first      <= first_addr;
            r_last       <= last_addr;
            r_cur_addr   <= first_addr;
`ifdef STREAMER_CHECKSUM_EN
            r_csum       <= '0;
            r_csum_phase <= 1'b0;
`endif
          end
        end
        S_LOAD: begin
          r_tx_data <= r_rdata;
`ifdef STREAMER_CHECKSUM_EN
          r_csum    <= r_csum + r_rdata;
`endif
        end
        // Raise the request, drop it once busy is seen alongside it.
        S_SEND: r_tx_start <= !(r_tx_start && tx_busy);
        S_NEXT: begin
          if (w_state_n == S_FETCH) begin
            r_cur_addr <= w_pass_end ? r_first
                                     : r_cur_addr + ADDR_W'(1);
`ifdef STREAMER_CHECKSUM_EN
            if (w_pass_end) begin
              r_csum       <= '0;
              r_csum_phase <= 1'b0;
            end
`endif
          end
`ifdef STREAMER_CHECKSUM_EN
          if (w_state_n == S_SEND) begin
            r_tx_data    <= r_csum;
            r_csum_phase <= 1'b1;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  assign tx_start = r_tx_start;
  assign tx_data  = r_tx_data;
  assign cur_addr = r_cur_addr;
  assign active   = (r_state != S_IDLE);
  assign done     = (r_state == S_DONE);

endmodule

// File: tb/tb_bram_uart_streamer.sv
// tb_bram_uart_streamer: randomized bench with a queue-based stream model
// and a transmitter responder for bram_uart_streamer.
module tb_bram_uart_streamer;

`ifdef STREAMER_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic       loop_en;
  logic [7:0] first_addr;
  logic [7:0] last_addr;
  logic       w_en;
  logic [7:0] w_addr;
  logic [7:0] w_data;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       active;
  logic [7:0] cur_addr;
  logic       done;

  bram_uart_streamer #(
    .DATA_W(8),
    .ADDR_W(8),
    .INIT_FILE("")
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .stop(stop),
    .loop_en(loop_en),
    .first_addr(first_addr),
    .last_addr(last_addr),
    .w_en(w_en),
    .w_addr(w_addr),
    .w_data(w_data),
    .tx_busy(tx_busy),
    .tx_start(tx_start),
    .tx_data(tx_data),
    .active(active),
    .cur_addr(cur_addr),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] addr;
    bit         csum;
  } ent_t;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         d_cnt = 0;
  logic [7:0] mem_m [256];
  ent_t       q[$];
  logic [7:0] cap_q[$];
  logic [7:0] m_first;
  logic [7:0] m_last;
  logic [7:0] m_sum;
  bit         m_running = 0;
  bit         m_done_exp = 0;
  bit         resp_en = 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] cap_at(input int i);
    if (i < cap_q.size()) return {24'h0, cap_q[i]};
    return 32'hdead_beef;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_pass();
    ent_t       e;
    logic [7:0] a;
    a = m_first;
    m_sum = 8'h00;
    forever begin
      e.addr = a;
      e.csum = 1'b0;
      q.push_back(e);
      if (a == m_last) break;
      a = a + 8'd1;
    end
    if (CS != 0) begin
      e.addr = m_last;
      e.csum = 1'b1;
      q.push_back(e);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    w_en = 1'b1;
    w_addr = a;
    w_data = d;
    mem_m[a] = d;
    tick();
    w_en = 1'b0;
  endtask

  task automatic start_pass(input logic [7:0] f, input logic [7:0] l,
                            input logic lp);
    int n;
    n = 0;
    while ((active || tx_busy) && n < 200) begin
      tick();
      n++;
    end
    m_first = f;
    m_last = l;
    loop_en = lp;
    first_addr = f;
    last_addr = l;
    q.delete();
    fill_pass();
    m_running = 1;
    m_done_exp = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    first_addr = 8'($urandom);
    last_addr = 8'($urandom);
    n = 0;
    while (!tx_start && n < 10) begin
      tick();
      n++;
    end
    chk("start latency", n, 3);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (m_running && n < 3000) begin
      tick();
      n++;
    end
    if (m_running) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done timeout: got running want done");
      m_running = 0;
      q.delete();
    end
  endtask

  task automatic wait_cap(input int k);
    int n;
    n = 0;
    while (cap_q.size() < k && n < 2000) begin
      tick();
      n++;
    end
    if (cap_q.size() < k) begin
      n_cmp++;
      n_bad++;
      $display("FAIL word wait: got %0d want %0d", cap_q.size(), k);
    end
  endtask

  // Transmitter: accepts a request after 0..2 cycles, busy for 1..4 cycles.
  initial begin
    tx_busy = 1'b0;
    forever begin
      tick();
      if (resp_en && tx_start && !tx_busy) begin
        repeat ($urandom_range(0, 2)) tick();
        tx_busy = 1'b1;
        repeat ($urandom_range(1, 4)) tick();
        tx_busy = 1'b0;
      end
    end
  end

  // Compare process.
  initial begin
    bit         p_rst;
    bit         p_busy;
    bit         p_done;
    bit         p_hold;
    logic [7:0] p_data;
    ent_t       e;
    logic [7:0] want;
    p_rst = 1;
    p_busy = 0;
    p_done = 0;
    p_hold = 0;
    p_data = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        p_rst = 1;
      end else begin
        if (p_rst) begin
          chk("reset tx_start", tx_start, 0);
          chk("reset active", active, 0);
          chk("reset done", done, 0);
          chk("reset cur_addr", cur_addr, 0);
          chk("reset tx_data", tx_data, 0);
        end else begin
          if (p_hold && (tx_start || tx_busy))
            chk("tx_data stable", tx_data, p_data);
          if (tx_start && tx_busy && !p_busy) begin
            if (q.size() == 0) begin
              n_cmp++;
              n_bad++;
              $display("FAIL extra word: got %0h want none", tx_data);
            end else begin
              e = q.pop_front();
              want = e.csum ? m_sum : mem_m[e.addr];
              if (!e.csum) m_sum = m_sum + want;
              chk("tx_data", tx_data, want);
              chk("cur_addr", cur_addr, e.addr);
            end
            cap_q.push_back(tx_data);
          end
          if (p_busy && !tx_busy && m_running && !m_done_exp) begin
            if (stop) begin
              q.delete();
              m_done_exp = 1;
            end else if (q.size() == 0) begin
              if (loop_en) fill_pass();
              else m_done_exp = 1;
            end
          end
          if (done) begin
            d_cnt++;
            chk("done while running", m_running, 1);
            chk("done expected", m_done_exp, 1);
            chk("words left at done", q.size(), 0);
            m_running = 0;
          end
          if (p_done) begin
            chk("idle after done", active, 0);
            chk("done one cycle", done, 0);
          end
        end
        p_rst = 0;
      end
      p_busy = tx_busy;
      p_done = done && !rst;
      p_hold = tx_start || tx_busy;
      p_data = tx_data;
    end
  end

  initial begin
    int d0;
    int len;
    int k;
    int n;
    logic [7:0] f;
    rst = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    loop_en = 1'b0;
    first_addr = 8'h00;
    last_addr = 8'h00;
    w_en = 1'b0;
    w_addr = 8'h00;
    w_data = 8'h00;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    stop = 1'b1;
    repeat (3) tick();
    chk("stop in idle", active, 0);
    stop = 1'b0;

    // Basic one-shot pass, with an ignored start while active.
    wr(8'h00, 8'h41);
    wr(8'h01, 8'h42);
    wr(8'h02, 8'h43);
    wr(8'h03, 8'h44);
    cap_q.delete();
    d0 = d_cnt;
    start_pass(8'h00, 8'h03, 1'b0);
    first_addr = 8'h80;
    last_addr = 8'h90;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done();
    chk("t1 count", cap_q.size(), 4 + CS);
    chk("t1 w0", cap_at(0), 32'h41);
    chk("t1 w1", cap_at(1), 32'h42);
    chk("t1 w2", cap_at(2), 32'h43);
    chk("t1 w3", cap_at(3), 32'h44);
    chk("t1 dones", d_cnt - d0, 1);

    // Loop, dropped after the sixth word.
    cap_q.delete();
    d0 = d_cnt;
    start_pass(8'h00, 8'h03, 1'b1);
    wait_cap(6);
    loop_en = 1'b0;
    wait_done();
    chk("t2 count", cap_q.size(), 8 + 2 * CS);
    chk("t2 restart", cap_at(4 + CS), 32'h41);
    chk("t2 last", cap_at(7 + CS), 32'h44);
    chk("t2 dones", d_cnt - d0, 1);

    // Window wrapping through the top of memory.
    wr(8'hfe, 8'h10);
    wr(8'hff, 8'h20);
    wr(8'h00, 8'h30);
    wr(8'h01, 8'h40);
    cap_q.delete();
    start_pass(8'hfe, 8'h01, 1'b0);
    wait_done();
    chk("t3 count", cap_q.size(), 4 + CS);
    chk("t3 w0", cap_at(0), 32'h10);
    chk("t3 w3", cap_at(3), 32'h40);

    // Stop during the second word.
    wr(8'h00, 8'h41);
    wr(8'h01, 8'h42);
    cap_q.delete();
    d0 = d_cnt;
    start_pass(8'h00, 8'h03, 1'b0);
    wait_cap(2);
    stop = 1'b1;
    wait_done();
    stop = 1'b0;
    chk("t4 count", cap_q.size(), 2);
    chk("t4 dones", d_cnt - d0, 1);

    // Reset while waiting on the transmitter.
    start_pass(8'h00, 8'h03, 1'b0);
    n = 0;
    while (!(active && tx_busy && !tx_start) && n < 200) begin
      tick();
      n++;
    end
    chk("t5 reached wait", n < 200, 1);
    rst = 1'b1;
    m_running = 0;
    q.delete();
    tick();
    rst = 1'b0;
    d0 = d_cnt;
    repeat (5) begin
      tick();
      chk("t5 no tx_start", tx_start, 0);
    end
    chk("t5 no done", d_cnt - d0, 0);
    cap_q.delete();
    start_pass(8'h00, 8'h03, 1'b0);
    wait_done();
    chk("t5 restart w0", cap_at(0), 32'h41);

    // Transmitter never goes busy: request held, no advance.
    resp_en = 0;
    cap_q.delete();
    start_pass(8'h02, 8'h03, 1'b0);
    repeat (20) tick();
    chk("t6 tx_start held", tx_start, 1);
    chk("t6 cur_addr held", cur_addr, 8'h02);
    chk("t6 active", active, 1);
    resp_en = 1;
    wait_done();
    chk("t6 count", cap_q.size(), 2 + CS);

    // Write to an address not fetched yet is what gets sent.
    cap_q.delete();
    start_pass(8'h00, 8'h03, 1'b0);
    wait_cap(1);
    wr(8'h03, 8'h99);
    wait_done();
    chk("t7 late write", cap_at(3), 32'h99);

    // Checksum pass.
    wr(8'h00, 8'h01);
    wr(8'h01, 8'h02);
    wr(8'h02, 8'hff);
    cap_q.delete();
    start_pass(8'h00, 8'h02, 1'b0);
    wait_done();
    chk("t8 count", cap_q.size(), 3 + CS);
    chk("t8 w2", cap_at(2), 32'hff);
`ifdef STREAMER_CHECKSUM_EN
    chk("t8 checksum", cap_at(3), 32'h02);
`endif

    // Randomized windows with occasional stop.
    for (int i = 0; i < 256; i++) wr(8'(i), 8'($urandom));
    for (int it = 0; it < 15; it++) begin
      f = 8'($urandom);
      len = $urandom_range(0, 9);
      cap_q.delete();
      start_pass(f, 8'(f + 8'(len)), 1'b0);
      if ($urandom_range(0, 2) == 0) begin
        k = $urandom_range(1, len + 1);
        wait_cap(k);
        stop = 1'b1;
        wait_done();
        stop = 1'b0;
      end else begin
        wait_done();
        chk("rand count", cap_q.size(), len + 1 + CS);
      end
    end

    repeat (5) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
